// File: rtl/arp_requester.sv
// ARP initiator: broadcasts a request for a target IPv4 address, then matches the reply on MAC RX.
// Optional one-entry result cache enabled by defining ARP_REQUESTER_CACHE_EN.
module arp_requester #(
  parameter logic [47:0] MY_HWADDR   = 48'h985aebdd1c65,
  parameter logic [31:0] MY_IP       = 32'hc0a80205,
  parameter int unsigned TIMEOUT_CYC = 1250000,
  parameter int unsigned MAX_TRIES   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lookup_req,
  input  logic [31:0] lookup_ip,
  output logic        lookup_busy,
  output logic        lookup_done,
  output logic        lookup_fail,
  output logic [47:0] lookup_hwaddr,
  output logic        count_req,
  output logic        count_reply,
  input  logic        rx_vld,
  input  logic        rx_last,
  input  logic        rx_err,
  input  logic        rx_crc_ok,
  input  logic        rx_busy,
  input  logic [10:0] rx_addr,
  input  logic [7:0]  rx_data,
  output logic        tx_req,
  output logic [10:0] tx_count,
  input  logic        tx_grant,
  input  logic [10:0] tx_addr,
  input  logic        tx_adv,
  input  logic        tx_last,
  output logic [7:0]  tx_data
);

  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TryW = $clog2(MAX_TRIES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [TryW-1:0] TryMax = TryW'(MAX_TRIES);

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StArb  = 4'b0010,
    StSend = 4'b0100,
    StWait = 4'b1000
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     tgt_ip_q, tgt_ip_d;
  logic [TryW-1:0] tries_q, tries_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [7:0]      tx_data_q, tx_byte;
  logic            rx_busy_q, is_reply_q, is_reply_d, byte_chk, reply_acc;
  logic [47:0]     rx_hwaddr_q, rx_hwaddr_d, hwaddr_q, hwaddr_d;
  logic            done_q, done_d, fail_q, fail_d, reply_q, reply_d;
  logic            cache_hit;
  logic [47:0]     cache_hw;

  function automatic logic [7:0] pick48(input logic [47:0] v, input logic [2:0] idx);
    logic [47:0] s;
    s = v >> {3'd5 - idx, 3'b000};
    return s[7:0];
  endfunction

  function automatic logic [7:0] pick32(input logic [31:0] v, input logic [1:0] idx);
    logic [31:0] s;
    s = v >> {2'd3 - idx, 3'b000};
    return s[7:0];
  endfunction

  // Request frame byte for the offset MAC TX is asking for.
  always_comb begin
    tx_byte = 8'h00;
    if (tx_addr < 11'd6) begin
      tx_byte = 8'hff;
    end else if (tx_addr < 11'd12) begin
      tx_byte = pick48(MY_HWADDR, 3'(tx_addr - 11'd6));
    end else if (tx_addr < 11'd22) begin
      case (tx_addr)
        11'd12, 11'd16: tx_byte = 8'h08;
        11'd13, 11'd18: tx_byte = 8'h06;
        11'd15, 11'd21: tx_byte = 8'h01;
        11'd19:         tx_byte = 8'h04;
        default:        tx_byte = 8'h00;
      endcase
    end else if (tx_addr < 11'd28) begin
      tx_byte = pick48(MY_HWADDR, 3'(tx_addr - 11'd22));
    end else if (tx_addr < 11'd32) begin
      tx_byte = pick32(MY_IP, 2'(tx_addr - 11'd28));
    end else if (tx_addr >= 11'd38 && tx_addr < 11'd42) begin
      tx_byte = pick32(tgt_ip_q, 2'(tx_addr - 11'd38));
    end
  end

  always_comb begin
    byte_chk = 1'b1;
    case (rx_addr)
      11'd12, 11'd16: byte_chk = (rx_data == 8'h08);
      11'd13:         byte_chk = (rx_data == 8'h06);
      11'd17, 11'd20: byte_chk = (rx_data == 8'h00);
      11'd21:         byte_chk = (rx_data == 8'h02);
      default: begin
        if (rx_addr < 11'd6) begin
          byte_chk = (rx_data == pick48(MY_HWADDR, rx_addr[2:0]));
        end else if (rx_addr >= 11'd28 && rx_addr < 11'd32) begin
          byte_chk = (rx_data == pick32(tgt_ip_q, 2'(rx_addr - 11'd28)));
        end else if (rx_addr >= 11'd38 && rx_addr < 11'd42) begin
          byte_chk = (rx_data == pick32(MY_IP, 2'(rx_addr - 11'd38)));
        end
      end
    endcase
  end

  // Sender MAC arrives MSB first, so a shift register ends up holding it in order.
  always_comb begin
    rx_hwaddr_d = rx_hwaddr_q;
    if (rx_vld && rx_addr >= 11'd22 && rx_addr < 11'd28) begin
      rx_hwaddr_d = {rx_hwaddr_q[39:0], rx_data};
    end
    is_reply_d = ((rx_busy && !rx_busy_q) || is_reply_q) && (!rx_vld || byte_chk);
    reply_acc  = rx_vld && rx_last && rx_crc_ok && !rx_err && is_reply_d;
  end

  always_comb begin
    state_d     = state_q;
    tgt_ip_d    = tgt_ip_q;
    tries_d     = tries_q;
    tmo_d       = tmo_q;
    hwaddr_d    = hwaddr_q;
    done_d      = 1'b0;
    fail_d      = 1'b0;
    reply_d     = 1'b0;
    tx_req      = 1'b0;
    tx_count    = 11'd0;
    count_req   = 1'b0;
    lookup_busy = 1'b1;
    unique case (state_q)
      StIdle: begin
        lookup_busy = 1'b0;
        if (lookup_req) begin
          if (cache_hit) begin
            done_d   = 1'b1;
            hwaddr_d = cache_hw;
          end else begin
            tgt_ip_d = lookup_ip;
            tries_d  = '0;
            state_d  = StArb;
          end
        end
      end
      StArb: begin
        tx_req   = 1'b1;
        tx_count = 11'd60;
        if (tx_grant) begin
          tries_d   = tries_q + 1'b1;
          count_req = 1'b1;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (tx_last) begin
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        tmo_d = tmo_q + 1'b1;
        if (reply_acc) begin
          hwaddr_d = rx_hwaddr_d;
          done_d   = 1'b1;
          reply_d  = 1'b1;
          state_d  = StIdle;
        end else if (tmo_q == TmoLast) begin
          if (tries_q < TryMax) begin
            state_d = StArb;
          end else begin
            fail_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      tgt_ip_q    <= '0;
      tries_q     <= '0;
      tmo_q       <= '0;
      tx_data_q   <= '0;
      rx_busy_q   <= 1'b0;
      is_reply_q  <= 1'b0;
      rx_hwaddr_q <= '0;
      hwaddr_q    <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      reply_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_ip_q    <= tgt_ip_d;
      tries_q     <= tries_d;
      tmo_q       <= tmo_d;
      rx_busy_q   <= rx_busy;
      is_reply_q  <= is_reply_d;
      rx_hwaddr_q <= rx_hwaddr_d;
      hwaddr_q    <= hwaddr_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      reply_q     <= reply_d;
      if (state_q == StSend && tx_adv) tx_data_q <= tx_byte;
    end
  end

`ifdef ARP_REQUESTER_CACHE_EN
  logic        cache_vld_q;
  logic [31:0] cache_ip_q;
  logic [47:0] cache_hw_q;

  assign cache_hit = cache_vld_q && (lookup_ip == cache_ip_q);
  assign cache_hw  = cache_hw_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_vld_q <= 1'b0;
      cache_ip_q  <= '0;
      cache_hw_q  <= '0;
    end else if (reply_d) begin
      cache_vld_q <= 1'b1;
      cache_ip_q  <= tgt_ip_q;
      cache_hw_q  <= rx_hwaddr_d;
    end else if (fail_d && tgt_ip_q == cache_ip_q) begin
      cache_vld_q <= 1'b0;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_hw  = '0;
`endif

  assign lookup_done   = done_q;
  assign lookup_fail   = fail_q;
  assign count_reply   = reply_q;
  assign lookup_hwaddr = hwaddr_q;
  assign tx_data       = (state_q == StSend) ? tx_data_q : 8'h00;

endmodule

// File: tb/tb_arp_requester.sv
// Scoreboarded bench for arp_requester: stimulus pushes expected events/bytes, a monitor pops them.
module tb_arp_requester;
  localparam logic [47:0] MyHw = 48'h985aebdd1c65;
  localparam logic [31:0] MyIp = 32'hc0a80205;
  localparam int T = 100;
  localparam int MaxTries = 3;

  typedef enum int {EvReq, EvDone, EvFail} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    int          cyc;
    logic [47:0] hw;
    logic        from_cache;
  } ev_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        lookup_req = 1'b0;
  logic [31:0] lookup_ip = '0;
  logic        lookup_busy, lookup_done, lookup_fail, count_req, count_reply;
  logic [47:0] lookup_hwaddr;
  logic        rx_vld = 1'b0, rx_last = 1'b0, rx_err = 1'b0, rx_crc_ok = 1'b0, rx_busy = 1'b0;
  logic [10:0] rx_addr = '0;
  logic [7:0]  rx_data = '0;
  logic        tx_req;
  logic [10:0] tx_count;
  logic        tx_grant = 1'b0, tx_adv = 1'b0, tx_last = 1'b0;
  logic [10:0] tx_addr = '0;
  logic [7:0]  tx_data;

  arp_requester #(
    .MY_HWADDR  (MyHw),
    .MY_IP      (MyIp),
    .TIMEOUT_CYC(T),
    .MAX_TRIES  (MaxTries)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_req   (lookup_req),
    .lookup_ip    (lookup_ip),
    .lookup_busy  (lookup_busy),
    .lookup_done  (lookup_done),
    .lookup_fail  (lookup_fail),
    .lookup_hwaddr(lookup_hwaddr),
    .count_req    (count_req),
    .count_reply  (count_reply),
    .rx_vld       (rx_vld),
    .rx_last      (rx_last),
    .rx_err       (rx_err),
    .rx_crc_ok    (rx_crc_ok),
    .rx_busy      (rx_busy),
    .rx_addr      (rx_addr),
    .rx_data      (rx_data),
    .tx_req       (tx_req),
    .tx_count     (tx_count),
    .tx_grant     (tx_grant),
    .tx_addr      (tx_addr),
    .tx_adv       (tx_adv),
    .tx_last      (tx_last),
    .tx_data      (tx_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  ev_t exp_ev[$];
  logic [7:0] exp_byte[$];
  int exp_req_cnt = 0, exp_reply_cnt = 0, seen_req_cnt = 0, seen_reply_cnt = 0;

  // Reference model state
  logic        m_cache_vld = 1'b0;
  logic [31:0] m_cache_ip = '0;
  logic [47:0] m_cache_hw = '0;
  logic [31:0] m_tgt = '0;
  int          m_tries = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got unexpected DUT event, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic push_ev(input ev_kind_e k, input int c, input logic [47:0] hw, input logic fc);
    ev_t e;
    e.kind = k; e.cyc = c; e.hw = hw; e.from_cache = fc;
    exp_ev.push_back(e);
  endtask

  task automatic pop_ev(input ev_kind_e k, input string name);
    ev_t e;
    if (exp_ev.size() == 0) begin
      fail_now(name);
      return;
    end
    e = exp_ev.pop_front();
    check({name, "_kind"}, 64'(k), 64'(e.kind));
    check({name, "_cycle"}, 64'(cyc), 64'(e.cyc));
    if (k == EvDone) begin
      check("lookup_hwaddr", lookup_hwaddr, e.hw);
      check("count_reply_with_done", count_reply, !e.from_cache);
    end
  endtask

  // Monitor
  logic adv_prev = 1'b0, rst_prev = 1'b0, req_prev = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (adv_prev && !rst_prev) begin
        if (exp_byte.size() == 0) fail_now("tx_byte");
        else check("tx_data", tx_data, exp_byte.pop_front());
      end
      if (tx_req && !req_prev) pop_ev(EvReq, "tx_req");
      check("tx_count", tx_count, tx_req ? 11'd60 : 11'd0);
      if (lookup_done) pop_ev(EvDone, "lookup_done");
      if (lookup_fail) pop_ev(EvFail, "lookup_fail");
      if (count_req) seen_req_cnt++;
      if (count_reply) seen_reply_cnt++;
      adv_prev = tx_adv;
      rst_prev = reset;
      req_prev = tx_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    lookup_req = 0; rx_vld = 0; rx_last = 0; rx_busy = 0; rx_crc_ok = 0;
    tx_grant = 0; tx_adv = 0; tx_last = 0;
    tick();
    tick();
    check("rst_busy", lookup_busy, 0);
    check("rst_done", lookup_done, 0);
    check("rst_fail", lookup_fail, 0);
    check("rst_hwaddr", lookup_hwaddr, 0);
    check("rst_count_req", count_req, 0);
    check("rst_count_reply", count_reply, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    m_cache_vld = 1'b0;
    tick();
  endtask

  task automatic start_lookup(input logic [31:0] ip, output bit hit);
    hit = 1'b0;
`ifdef ARP_REQUESTER_CACHE_EN
    hit = m_cache_vld && (m_cache_ip == ip);
`endif
    lookup_req = 1'b1;
    lookup_ip  = ip;
    if (hit) begin
      push_ev(EvDone, cyc + 1, m_cache_hw, 1'b1);
    end else begin
      push_ev(EvReq, cyc + 1, '0, 1'b0);
      m_tgt   = ip;
      m_tries = 0;
    end
    tick();
    lookup_req = 1'b0;
  endtask

  // Acts as the MAC TX side; abort_at >= 0 pulses reset at that byte offset.
  task automatic serve_tx(input int delay, input int abort_at, output int last_c);
    logic [479:0] v;
    int guard = 0;
    v = {48'hffffffffffff, MyHw, 16'h0806, 16'h0001, 16'h0800, 16'h0604, 16'h0001,
         MyHw, MyIp, 48'h0, m_tgt, 144'h0};
    last_c = cyc;
    while (!tx_req && guard < 3 * T) begin
      tick();
      guard++;
    end
    if (!tx_req) begin
      fail_now("tx_req_wait");
      return;
    end
    repeat (delay) tick();
    tx_grant = 1'b1;
    m_tries++;
    exp_req_cnt++;
    for (int i = 0; i < 60; i++) if (abort_at < 0 || i < abort_at) exp_byte.push_back(v[479-8*i -: 8]);
    tick();
    tx_grant = 1'b0;
    for (int i = 0; i <= 60; i++) begin
      tx_adv  = (i < 60);
      tx_addr = 11'((i < 60) ? i : 59);
      tx_last = (i == 60);
      if (i == abort_at) reset = 1'b1;
      last_c = cyc;
      tick();
      if (i == abort_at) begin
        reset = 1'b0; tx_adv = 1'b0; tx_last = 1'b0;
        m_cache_vld = 1'b0;
        check("abort_tx_data", tx_data, 0);
        check("abort_tx_req", tx_req, 0);
        check("abort_busy", lookup_busy, 0);
        return;
      end
    end
    tx_adv = 1'b0;
    tx_last = 1'b0;
  endtask

  task automatic expect_timeout(input int c);
    if (m_tries < MaxTries) begin
      push_ev(EvReq, c + T + 1, '0, 1'b0);
    end else begin
      push_ev(EvFail, c + T + 1, '0, 1'b0);
      if (m_cache_ip == m_tgt) m_cache_vld = 1'b0;
    end
  endtask

  // good: frame content/CRC would pass; c: cycle of the tx_last that opened the reply window.
  task automatic send_rx(input logic [47:0] dest, input logic [47:0] shw, input logic [31:0] sip,
                         input logic [31:0] tip, input bit crc_ok, input bit good, input int c);
    logic [335:0] v;
    bit accept;
    v = {dest, shw, 16'h0806, 16'h0001, 16'h0800, 16'h0604, 16'h0002, shw, sip, 48'h0, tip};
    accept = good && crc_ok && (cyc + 41 > c) && (cyc + 41 <= c + T);
    for (int i = 0; i < 42; i++) begin
      rx_busy = 1'b1; rx_vld = 1'b1; rx_addr = 11'(i); rx_data = v[335-8*i -: 8];
      rx_last = (i == 41);
      rx_crc_ok = (i == 41) ? crc_ok : 1'b0;
      if (i == 41 && accept) begin
        push_ev(EvDone, cyc + 1, shw, 1'b0);
        exp_reply_cnt++;
        m_cache_vld = 1'b1; m_cache_ip = m_tgt; m_cache_hw = shw;
      end
      tick();
    end
    rx_vld = 1'b0; rx_last = 1'b0; rx_busy = 1'b0; rx_crc_ok = 1'b0;
    tick();
  endtask

  // reply_try: transmission after which a valid reply is sent (0 = never).
  task automatic full_lookup(input logic [31:0] ip, input logic [47:0] hw, input int reply_try);
    bit hit;
    int c = 0;
    start_lookup(ip, hit);
    if (hit) begin
      tick();
      return;
    end
    for (int t = 1; t <= MaxTries; t++) begin
      serve_tx(int'($urandom_range(0, 6)), -1, c);
      if (t == reply_try) begin
        repeat ($urandom_range(0, 40)) tick();
        send_rx(MyHw, hw, ip, MyIp, 1'b1, 1'b1, c);
        tick();
        return;
      end
      expect_timeout(c);
    end
    wait_until(c + T + 3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    bit hit;
    int c = 0;
    do_reset();

    // Basic lookup, grant after 5 cycles
    start_lookup(32'hc0a80202, hit);
    if (!hit) begin
      serve_tx(5, -1, c);
      repeat (3) tick();
      send_rx(MyHw, 48'h985aebdd1c64, 32'hc0a80202, MyIp, 1'b1, 1'b1, c);
      tick();
    end

    // No reply at all: three requests then fail
    full_lookup(32'hc0a80207, 48'h0, 0);

    // Bad CRC and wrong sender IP ignored; valid reply after the retransmission
    start_lookup(32'hc0a80204, hit);
    serve_tx(1, -1, c);
    send_rx(MyHw, 48'h985aebdd1c66, 32'hc0a80204, MyIp, 1'b0, 1'b1, c);
    send_rx(MyHw, 48'h985aebdd1c66, 32'hc0a80203, MyIp, 1'b1, 1'b0, c);
    expect_timeout(c);
    serve_tx(2, -1, c);
    send_rx(MyHw, 48'h985aebdd1c66, 32'hc0a80204, MyIp, 1'b1, 1'b1, c);
    tick();

    // Reply lands on the timeout cycle; lookup_req during WAIT must be ignored
    start_lookup(32'hc0a80206, hit);
    serve_tx(int'($urandom_range(0, 6)), -1, c);
    wait_until(c + 5);
    lookup_req = 1'b1; lookup_ip = 32'hc0a80299;
    tick();
    lookup_req = 1'b0;
    wait_until(c + T - 41);
    send_rx(MyHw, 48'h02aabbccdd06, 32'hc0a80206, MyIp, 1'b1, 1'b1, c);
    repeat (3) tick();

    for (int k = 0; k < 6; k++) begin
      full_lookup({24'hc0a802, 8'($urandom_range(10, 12))}, {16'h0200, 32'($urandom)},
                  int'($urandom_range(0, 3)));
      repeat (2) tick();
    end

    // Reset in the middle of a transmission, then a fresh lookup and a repeat
    start_lookup(32'hc0a80202, hit);
    if (!hit) serve_tx(2, 20, c);
    tick();
    full_lookup(32'hc0a80202, 48'h985aebdd1c64, 1);
    full_lookup(32'hc0a80202, 48'h985aebdd1c64, 1);

    repeat (5) tick();
    check("events_outstanding", 64'(exp_ev.size()), 0);
    check("bytes_outstanding", 64'(exp_byte.size()), 0);
    check("count_req_total", 64'(seen_req_cnt), 64'(exp_req_cnt));
    check("count_reply_total", 64'(seen_reply_cnt), 64'(exp_reply_cnt));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
